puf_response_collector: RTL
===========================

# puf_response_collector

Receiving end of the TERO evaluation controller's response interface. Captures the shared oscillation counter on each `store_response_puf` strobe, divides by the repetition count (right shift), and stores one saturated average frequency per loop. When the controller raises `done`, it derives pairwise comparison response bits and drains the per-loop averages over a valid/ready stream.

## Interface
- `NUM_LOOPS`, 4: number of TERO loops; must be even and ≥ 2.
- `CNT_BITS`, 32: width of the shared oscillation counter.
- `AVG_SHIFT`, 12: right shift applied to the counter; equals log2(REPETITIONS), i.e. `REPETITIONS_BITS-1`.
- `FREQ_BITS`, 16: width of each stored average.
- `SEL_W`, `$clog2(NUM_LOOPS-1)+1`: loop-index width, identical to the controller's `select_puf`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `store_response_puf`  in  1  single-cycle capture strobe from the controller.
- `select_puf`  in  SEL_W  loop index valid with the strobe.
- `count_in`  in  CNT_BITS  shared counter value valid with the strobe.
- `done_in`  in  1  controller `done` level.
- `out_valid`  out  1  average record valid.
- `out_ready`  in  1  downstream accepts record.
- `out_idx`  out  SEL_W  loop index of the record.
- `out_freq`  out  FREQ_BITS  average frequency of the record.
- `out_last`  out  1  record is loop `NUM_LOOPS-1`.
- `resp_valid`  out  1  `resp_bits` and `missing_mask` are valid.
- `resp_bits`  out  NUM_LOOPS/2  pairwise response.
- `missing_mask`  out  NUM_LOOPS  loops not captured this run.
- `err_range`  out  1  sticky: strobe with `select_puf ≥ NUM_LOOPS`.
- `err_overrun`  out  1  sticky: strobe outside COLLECT.

## Operation
- States: COLLECT, CMP, DRAIN, HOLD.
- COLLECT:
  - On strobe with in-range index: `freq[idx] <= min(count_in >> AVG_SHIFT, 2^FREQ_BITS-1)`; `loaded[idx] <= 1`. A repeated index overwrites the previous value.
  - On strobe with out-of-range index: nothing is stored; `err_range <= 1`.
  - On `done_in`=1: go to CMP.
  - A strobe in the same cycle as `done_in` is captured first, then the transition occurs.
- CMP (1 cycle):
  - `resp_bits[k] <= (freq[2k] > freq[2k+1])`; a tie gives 0.
  - `missing_mask <= ~loaded`.
  - `resp_valid <= 1`; drain counter set to 0; go to DRAIN.
- DRAIN:
  - `out_valid`=1 with `out_idx`=drain counter and `out_freq`=`freq[out_idx]`.
  - Drain counter advances only on `out_valid && out_ready`. Outputs are held stable while stalled.
  - Acceptance with `out_last`=1 goes to HOLD.
- HOLD:
  - `resp_valid` stays 1.
  - When `done_in`=0: return to COLLECT, clear `loaded`, clear `resp_valid`, and clear both error flags.
- A strobe in CMP, DRAIN or HOLD is ignored and sets `err_overrun`.
- A missing loop reports `freq`=0, or its value from the previous run if that run captured it; the consumer uses `missing_mask` to tell.

## Timing
- Reset:
  - State COLLECT.
  - All `freq` entries, `loaded`, `resp_bits` and `missing_mask` cleared to 0.
  - All outputs 0.
- Reset mid-DRAIN: `out_valid` and `resp_valid` are 0 in the cycle after reset is sampled, and the run is discarded.
- Capture latency: the strobe at edge N makes `freq[idx]` valid from edge N+1. The strobe carries no back-pressure, so capture must be single-cycle.
- `done_in` sampled high at edge N: CMP during cycle N+1, and `resp_valid`/`out_valid` high from edge N+2.
- Full drain with `out_ready` tied high takes NUM_LOOPS cycles. HOLD is entered on the edge that accepts the last record.
- The controller guarantees at least 2 cycles between its last strobe and `done`. The block must not rely on this gap.

## Structure
- Shared package `puf_pkg` holds:
  - the state enum `collector_state_t` (2-bit);
  - the `SEL_W` derivation as a function shared with the controller.
- The frequency store is a register array, not BRAM, because CMP reads all entries in parallel.
- One sub-module, `freq_sat_shift`: combinational shift plus saturation, `CNT_BITS` to `FREQ_BITS`.

## Test plan
- **Basic run:** strobes idx 0..3 with `count_in` 0x0040_3000, 0x0020_0000, 0x0001_0000, 0x0001_2000, then `done_in`=1, `out_ready`=1 → records (0,0x403), (1,0x200), (2,0x010), (3,0x012); `resp_bits`=2'b01; `missing_mask`=0.
- **Saturation and tie:** `count_in`=0x1000_0000 on idx 0 and 0x0FFF_F000 on idx 1 → `freq0`=0xFFFF, `freq1`=0xFFFF; `resp_bits[0]`=0.
- **Back-pressure:** `out_ready` toggled 1,0,0,1 during DRAIN → `out_idx`/`out_freq` stable while `out_ready`=0; each index emitted exactly once; `out_last` only on idx 3.
- **Missing and out-of-range:** strobe idx 1 only, plus a strobe with `select_puf`=5 → `missing_mask`=4'b1101, `err_range`=1.
- **Overrun and restart:** strobe during HOLD → `err_overrun`=1. Then `done_in`=0 → COLLECT with flags, `loaded` and `resp_valid` cleared.
- **Reset mid-DRAIN:** reset asserted after 2 records → next cycle `out_valid`=0, `resp_valid`=0, state COLLECT, all `freq` entries 0.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the TERO PUF evaluation controller and response collector.
package puf_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CMP     = 2'd1,
    DRAIN   = 2'd2,
    HOLD    = 2'd3
  } collector_state_t;

  // Loop-index width; must match the controller's select_puf width.
  function automatic int sel_width(input int num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

endpackage

// File: rtl/puf_response_collector_freq_sat_shift.sv
// Divides the raw oscillation count by the repetition count and clamps it to the stored width.
module freq_sat_shift #(
  parameter int CNT_BITS  = 32,
  parameter int AVG_SHIFT = 12,
  parameter int FREQ_BITS = 16
) (
  input  logic [CNT_BITS-1:0]  count_i,
  output logic [FREQ_BITS-1:0] freq_o
);

  logic [CNT_BITS-1:0] shifted;

  assign shifted = count_i >> AVG_SHIFT;
  // Any set bit above the stored width means the average does not fit.
  assign freq_o  = (|shifted[CNT_BITS-1:FREQ_BITS]) ? {FREQ_BITS{1'b1}}
                                                     : shifted[FREQ_BITS-1:0];

endmodule

// File: rtl/puf_response_collector.sv
// Captures per-loop average frequencies, derives pairwise response bits on done,
// and drains the averages over a valid/ready stream.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int NUM_LOOPS = 4,
  parameter int CNT_BITS  = 32,
  parameter int AVG_SHIFT = 12,
  parameter int FREQ_BITS = 16,
  parameter int SEL_W     = sel_width(NUM_LOOPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   store_response_puf,
  input  logic [SEL_W-1:0]       select_puf,
  input  logic [CNT_BITS-1:0]    count_in,
  input  logic                   done_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_idx,
  output logic [FREQ_BITS-1:0]   out_freq,
  output logic                   out_last,
  output logic                   resp_valid,
  output logic [NUM_LOOPS/2-1:0] resp_bits,
  output logic [NUM_LOOPS-1:0]   missing_mask,
  output logic                   err_range,
  output logic                   err_overrun
);

  localparam int IDX_W = $clog2(NUM_LOOPS);
  localparam int NPAIR = NUM_LOOPS / 2;
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_LOOPS - 1);
  localparam logic [SEL_W-1:0] LOOPS_SEL = SEL_W'(NUM_LOOPS);

  collector_state_t       state_q;
  logic [FREQ_BITS-1:0]   freq_q [NUM_LOOPS];
  logic [NUM_LOOPS-1:0]   loaded_q;
  logic [NPAIR-1:0]       resp_bits_q;
  logic [NUM_LOOPS-1:0]   missing_q;
  logic                   resp_valid_q;
  logic                   out_valid_q;
  logic [SEL_W-1:0]       out_idx_q;
  logic [FREQ_BITS-1:0]   out_freq_q;
  logic                   out_last_q;
  logic                   err_range_q;
  logic                   err_overrun_q;

  logic [FREQ_BITS-1:0]   cap_freq_d;
  logic [NPAIR-1:0]       cmp_bits_d;
  logic [SEL_W-1:0]       next_idx_d;
  logic                   in_range_d;

  freq_sat_shift #(
    .CNT_BITS  (CNT_BITS),
    .AVG_SHIFT (AVG_SHIFT),
    .FREQ_BITS (FREQ_BITS)
  ) u_sat (
    .count_i (count_in),
    .freq_o  (cap_freq_d)
  );

  // All pairs compared in parallel, hence the register array rather than RAM.
  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_cmp
    assign cmp_bits_d[gi] = freq_q[2*gi] > freq_q[2*gi+1];
  end

  assign in_range_d = select_puf < LOOPS_SEL;
  assign next_idx_d = out_idx_q + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      for (int i = 0; i < NUM_LOOPS; i++) freq_q[i] <= '0;
      loaded_q      <= '0;
      resp_bits_q   <= '0;
      missing_q     <= '0;
      resp_valid_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_freq_q    <= '0;
      out_last_q    <= 1'b0;
      err_range_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (store_response_puf && state_q != COLLECT) err_overrun_q <= 1'b1;

      case (state_q)
        COLLECT: begin
          if (store_response_puf) begin
            if (in_range_d) begin
              for (int i = 0; i < NUM_LOOPS; i++) begin
                if (select_puf == SEL_W'(i)) begin
                  freq_q[i]   <= cap_freq_d;
                  loaded_q[i] <= 1'b1;
                end
              end
            end else begin
              err_range_q <= 1'b1;
            end
          end
          if (done_in) state_q <= CMP;
        end

        CMP: begin
          resp_bits_q  <= cmp_bits_d;
          missing_q    <= ~loaded_q;
          resp_valid_q <= 1'b1;
          out_valid_q  <= 1'b1;
          out_idx_q    <= '0;
          out_freq_q   <= freq_q[0];
          out_last_q   <= 1'b0;
          state_q      <= DRAIN;
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= HOLD;
            end else begin
              out_idx_q  <= next_idx_d;
              out_freq_q <= freq_q[next_idx_d[IDX_W-1:0]];
              out_last_q <= (next_idx_d == LAST_IDX);
            end
          end
        end

        HOLD: begin
          // Leaving HOLD starts a fresh run, so it also wins over an overrun seen this cycle.
          if (!done_in) begin
            loaded_q      <= '0;
            resp_valid_q  <= 1'b0;
            err_range_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            state_q       <= COLLECT;
          end
        end

        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_idx      = out_idx_q;
  assign out_freq     = out_freq_q;
  assign out_last     = out_last_q;
  assign resp_valid   = resp_valid_q;
  assign resp_bits    = resp_bits_q;
  assign missing_mask = missing_q;
  assign err_range    = err_range_q;
  assign err_overrun  = err_overrun_q;

endmodule
